varcic_mc: RTL

- Multi-channel, variable-rate CIC decimator for the receive DDC chain.
- Sits between the CORDIC mixer output and the FIR decimator stage.
- Any integer decimation 1..2^DEC_WIDTH-1 is supported. Bit-growth shift is computed per rate, not enumerated by hand.
- Output rounds to nearest with saturation.
- A rate change triggers a flush-and-settle sequence so no transient samples leave the block.

---
 rtl/varcic_pkg.sv | 58 +++++
 rtl/cic_channel.sv | 74 +++++++
 rtl/varcic_mc.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/varcic_pkg.sv
// Shared types and helpers for the variable-rate multi-channel CIC decimator.
// Growth is derived from the rate at elaboration; rounding/saturation is generic in width.
package varcic_pkg;

  localparam int unsigned GROWTH_W = 8;
  localparam int unsigned SAT_W    = 128;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    SETTLE = 2'd2
  } cic_state_e;

  // ceil(stages*log2(d)) == bit length of (d^stages - 1); d = 0 behaves as 1
  function automatic int unsigned cic_growth(input int unsigned stages, input int unsigned d);
    logic [63:0]  pow;
    logic [63:0]  rem;
    int unsigned  g;
    pow = 64'd1;
    for (int unsigned i = 0; i < stages; i++) begin
      pow = pow * 64'((d == 0) ? 1 : d);
    end
    rem = pow - 64'd1;
    g   = 0;
    for (int i = 0; i < 64; i++) begin
      if (rem != 64'd0) begin
        rem = rem >> 1;
        g   = g + 1;
      end
    end
    return g;
  endfunction

  // Drop lsb bits with round-half-up (or left-align when lsb <= 0), then clamp to out_width signed
  function automatic logic signed [SAT_W-1:0] round_sat(input logic signed [SAT_W-1:0] value,
                                                        input int                      lsb,
                                                        input int unsigned             out_width);
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] r;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = SAT_W'(1);
    if (lsb > 0) begin
      r = ((value >>> (lsb - 1)) + one) >>> 1;
    end else begin
      r = value <<< (-lsb);
    end
    hi = (one <<< (out_width - 1)) - one;
    lo = -(one <<< (out_width - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/cic_channel.sv
// One CIC channel: registered integrator chain at input rate, comb chain
// updated on each decimation event with a registered result.
module cic_channel
  import varcic_pkg::*;
#(
  parameter int unsigned STAGES    = 5,
  parameter int unsigned IN_WIDTH  = 18,
  parameter int unsigned ACC_WIDTH = 48
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear_i,
  input  logic                        in_strobe_i,
  input  logic                        dec_evt_i,
  input  logic signed [IN_WIDTH-1:0]  data_i,
  output logic signed [ACC_WIDTH-1:0] comb_o
);

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  acc_t integ_q [STAGES];
  acc_t integ_d [STAGES];
  acc_t dly_q   [STAGES];
  acc_t dly_d   [STAGES];
  acc_t diff    [STAGES];
  acc_t comb_q;
  acc_t comb_d;

  // Comb differences are combinational off the delay registers so every stage
  // sees the same decimated sample; only the final result is registered.
  always_comb begin
    integ_d = integ_q;
    dly_d   = dly_q;
    comb_d  = comb_q;
    diff[0] = integ_q[STAGES-1] - dly_q[0];
    for (int s = 1; s < STAGES; s++) begin
      diff[s] = diff[s-1] - dly_q[s];
    end
    if (clear_i) begin
      integ_d = '{default: '0};
      dly_d   = '{default: '0};
      comb_d  = '0;
    end else begin
      if (in_strobe_i) begin
        integ_d[0] = integ_q[0] + ACC_WIDTH'(data_i);
        for (int s = 1; s < STAGES; s++) begin
          integ_d[s] = integ_q[s] + integ_q[s-1];
        end
      end
      if (dec_evt_i) begin
        dly_d[0] = integ_q[STAGES-1];
        for (int s = 1; s < STAGES; s++) begin
          dly_d[s] = diff[s-1];
        end
        comb_d = diff[STAGES-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ_q <= '{default: '0};
      dly_q   <= '{default: '0};
      comb_q  <= '0;
    end else begin
      integ_q <= integ_d;
      dly_q   <= dly_d;
      comb_q  <= comb_d;
    end
  end

  assign comb_o = comb_q;

endmodule

// File: rtl/varcic_mc.sv
// Multi-channel variable-rate CIC decimator with rate-change flush/settle control
// and round-to-nearest saturating output stage.
module varcic_mc
  import varcic_pkg::*;
#(
  parameter int unsigned STAGES    = 5,
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned IN_WIDTH  = 18,
  parameter int unsigned OUT_WIDTH = 18,
  parameter int unsigned DEC_WIDTH = 6,
  parameter int unsigned ACC_WIDTH = 48
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [DEC_WIDTH-1:0]            decimation,
  input  logic                            in_strobe,
  input  logic [CHANNELS*IN_WIDTH-1:0]    in_data,
  output logic                            out_strobe,
  output logic [CHANNELS*OUT_WIDTH-1:0]   out_data,
  output logic                            settling
);

  localparam int unsigned NUM_RATES = 1 << DEC_WIDTH;
  localparam int unsigned CNT_W     = $clog2(STAGES + 1);

  if (ACC_WIDTH < IN_WIDTH + cic_growth(STAGES, NUM_RATES - 1)) begin : g_acc_too_narrow
    $error("varcic_mc: ACC_WIDTH cannot hold growth at the maximum decimation");
  end
  if (ACC_WIDTH > SAT_W) begin : g_acc_too_wide
    $error("varcic_mc: ACC_WIDTH exceeds rounding datapath width");
  end

  cic_state_e                   state_q, state_d;
  logic [DEC_WIDTH-1:0]         dec_active_q, dec_active_d;
  logic [DEC_WIDTH-1:0]         sample_no_q, sample_no_d;
  logic [GROWTH_W-1:0]          g_q, g_d;
  logic [CNT_W-1:0]             settle_cnt_q, settle_cnt_d;
  logic                         dec_evt_q, dec_evt_d;
  logic                         comb_valid_q, comb_valid_d;
  logic                         out_strobe_q, out_strobe_d;
  logic                         settling_q, settling_d;
  logic [CHANNELS*OUT_WIDTH-1:0] out_data_q, out_data_d;

  logic [DEC_WIDTH-1:0]         dec_eff;
  logic                         rate_change;
  logic                         flush;
  logic                         integ_en;
  int                           out_lsb;
  logic [GROWTH_W-1:0]          g_tab [NUM_RATES];
  logic signed [ACC_WIDTH-1:0]  comb_out [CHANNELS];
  logic [CHANNELS*OUT_WIDTH-1:0] rounded;

  // Growth per rate is a constant table, so no runtime log/multiply is built
  for (genvar d = 0; d < NUM_RATES; d++) begin : g_growth
    assign g_tab[d] = GROWTH_W'(cic_growth(STAGES, d));
  end

  assign dec_eff     = (decimation == '0) ? DEC_WIDTH'(1) : decimation;
  assign rate_change = (dec_eff != dec_active_q);
  assign flush       = (state_q == FLUSH);
  assign integ_en    = in_strobe && !flush;
  assign out_lsb     = int'(g_q) + int'(IN_WIDTH) - int'(OUT_WIDTH);

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    cic_channel #(
      .STAGES    (STAGES),
      .IN_WIDTH  (IN_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_chan (
      .clk         (clock),
      .rst_n       (reset_n),
      .clear_i     (flush),
      .in_strobe_i (integ_en),
      .dec_evt_i   (dec_evt_q),
      .data_i      (in_data[ch*IN_WIDTH +: IN_WIDTH]),
      .comb_o      (comb_out[ch])
    );
    assign rounded[ch*OUT_WIDTH +: OUT_WIDTH] =
      OUT_WIDTH'(round_sat(SAT_W'(comb_out[ch]), out_lsb, OUT_WIDTH));
  end

  // Rate FSM and sample counter
  always_comb begin
    state_d      = state_q;
    dec_active_d = dec_active_q;
    g_d          = g_q;
    settle_cnt_d = settle_cnt_q;
    sample_no_d  = sample_no_q;
    dec_evt_d    = 1'b0;
    comb_valid_d = 1'b0;

    if (integ_en) begin
      if (sample_no_q == dec_active_q - DEC_WIDTH'(1)) begin
        sample_no_d = '0;
        dec_evt_d   = 1'b1;
      end else begin
        sample_no_d = sample_no_q + DEC_WIDTH'(1);
      end
    end

    case (state_q)
      RUN: begin
        if (rate_change) begin
          state_d = FLUSH;
        end else begin
          comb_valid_d = dec_evt_q;
        end
      end
      FLUSH: begin
        sample_no_d  = '0;
        dec_active_d = dec_eff;
        g_d          = g_tab[dec_eff];
        settle_cnt_d = CNT_W'(STAGES);
        state_d      = SETTLE;
      end
      SETTLE: begin
        if (rate_change) begin
          state_d = FLUSH;
        end else if (dec_evt_q) begin
          if (settle_cnt_q <= CNT_W'(1)) begin
            settle_cnt_d = '0;
            state_d      = RUN;
          end else begin
            settle_cnt_d = settle_cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = FLUSH;
      end
    endcase
  end

  // Output stage: qualified comb results become registered outputs
  always_comb begin
    out_strobe_d = comb_valid_q;
    out_data_d   = out_data_q;
    settling_d   = (state_d != RUN);
    if (comb_valid_q) begin
      out_data_d = rounded;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SETTLE;
      dec_active_q <= DEC_WIDTH'(1);
      g_q          <= '0;
      settle_cnt_q <= CNT_W'(STAGES);
      sample_no_q  <= '0;
      dec_evt_q    <= 1'b0;
      comb_valid_q <= 1'b0;
      out_strobe_q <= 1'b0;
      out_data_q   <= '0;
      settling_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      dec_active_q <= dec_active_d;
      g_q          <= g_d;
      settle_cnt_q <= settle_cnt_d;
      sample_no_q  <= sample_no_d;
      dec_evt_q    <= dec_evt_d;
      comb_valid_q <= comb_valid_d;
      out_strobe_q <= out_strobe_d;
      out_data_q   <= out_data_d;
      settling_q   <= settling_d;
    end
  end

  assign out_strobe = out_strobe_q;
  assign out_data   = out_data_q;
  assign settling   = settling_q;

endmodule
